// File: rtl/i2s_playback_serializer.sv
// I2S master playback stage: sample-pair FIFO feeding a 64-bit-frame serializer with clock-enable derived BCLK/LRCLK.
// A pair pushed into an empty FIFO plays from the next frame boundary; s_ready drops only when the FIFO is full.
module i2s_playback_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 20
) (
    input  logic                          board_clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_left,
    input  logic [DATA_WIDTH-1:0]         s_right,
    output logic                          ac_bclk,
    output logic                          ac_pblrc,
    output logic                          ac_pbdat,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [15:0]                   underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int DIVW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } pair_t;

    pair_t                 mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         level_d;
    logic [DIVW-1:0]       div_cnt_q;
    logic [5:0]            bit_cnt_q;
    logic                  bclk_q;
    logic                  lrc_q;
    logic                  dat_q;
    logic                  frame_start_q;
    logic                  underrun_q;
    logic [DATA_WIDTH-1:0] left_q;
    logic [DATA_WIDTH-1:0] right_q;
    logic [15:0]           underrun_cnt_q;
    logic [15:0]           underrun_cnt_d;

    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        tick;
    logic        fall_evt;
    logic        load_evt;
    logic [5:0]  next_bit;
    logic [4:0]  slot_k;
    logic [31:0] slot_word;
    logic        slot_bit;

    assign fifo_empty = (level_q == '0);
    assign s_ready    = (level_q != LW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign tick       = en && (div_cnt_q == DIVW'(BCLK_DIV - 1));
    assign fall_evt   = tick && bclk_q;
    assign next_bit   = bit_cnt_q + 6'd1;
    assign load_evt   = fall_evt && (next_bit == 6'd0);
    assign pop        = load_evt && !fifo_empty;
    assign slot_k     = next_bit[4:0];

    // Sample left-justified at bit 30 so slot bit k is word bit 31-k; k=0 and k>DATA_WIDTH read zeros.
    always_comb begin
        slot_word = 32'(next_bit[5] ? right_q : left_q) << (31 - DATA_WIDTH);
        slot_bit  = slot_word[~slot_k];
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (load_evt && fifo_empty && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge board_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{left: s_left, right: s_right};
        end
    end

    always_ff @(posedge board_clk) begin
        if (reset) begin
            underrun_cnt_q <= '0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    always_ff @(posedge board_clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            div_cnt_q     <= '0;
            bit_cnt_q     <= 6'h3F;
            bclk_q        <= 1'b0;
            lrc_q         <= 1'b0;
            dat_q         <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            left_q        <= '0;
            right_q       <= '0;
        end else begin
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            level_q       <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // Disabling parks the frame one bit before slot 0, so the next falling event starts a frame.
            if (!en) begin
                div_cnt_q <= '0;
                bit_cnt_q <= 6'h3F;
                bclk_q    <= 1'b0;
                lrc_q     <= 1'b0;
                dat_q     <= 1'b0;
            end else if (tick) begin
                div_cnt_q <= '0;
                bclk_q    <= ~bclk_q;
                if (fall_evt) begin
                    bit_cnt_q <= next_bit;
                    lrc_q     <= next_bit[5];
                    dat_q     <= slot_bit;
                    if (load_evt) begin
                        frame_start_q <= 1'b1;
                        if (fifo_empty) begin
                            left_q     <= '0;
                            right_q    <= '0;
                            underrun_q <= 1'b1;
                        end else begin
                            left_q  <= mem_q[rd_ptr_q].left;
                            right_q <= mem_q[rd_ptr_q].right;
                        end
                    end
                end
            end else begin
                div_cnt_q <= div_cnt_q + DIVW'(1);
            end
        end
    end

    assign ac_bclk      = bclk_q;
    assign ac_pblrc     = lrc_q;
    assign ac_pbdat     = dat_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_i2s_playback_serializer.sv
// Bench for i2s_playback_serializer: scoreboard of accepted pairs against frames captured on BCLK rising edges.
module tb_i2s_playback_serializer;
    localparam int DW  = 24;
    localparam int FD  = 4;
    localparam int DIV = 2;
    localparam int LW  = $clog2(FD) + 1;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_left = '0;
    logic [DW-1:0] s_right = '0;
    logic          ac_bclk;
    logic          ac_pblrc;
    logic          ac_pbdat;
    logic          frame_start;
    logic          underrun;
    logic [15:0]   underrun_cnt;
    logic [LW-1:0] fifo_level;

    int    checks = 0;
    int    failures = 0;
    int    fs_cnt = 0;
    int    ur_cnt = 0;
    pair_t sb_q[$];

    i2s_playback_serializer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD),
        .BCLK_DIV(DIV)
    ) dut (
        .board_clk(clk),
        .reset(reset),
        .en(en),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_left(s_left),
        .s_right(s_right),
        .ac_bclk(ac_bclk),
        .ac_pblrc(ac_pblrc),
        .ac_pbdat(ac_pbdat),
        .frame_start(frame_start),
        .underrun(underrun),
        .underrun_cnt(underrun_cnt),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_stream(input logic [DW-1:0] l, input logic [DW-1:0] r);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < 64; i++) begin
            int k;
            logic [DW-1:0] smp;
            k = i % 32;
            smp = (i < 32) ? l : r;
            if (k >= 1 && k <= DW) s[i] = smp[DW-k];
        end
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (frame_start === 1'b1) fs_cnt++;
        if (underrun === 1'b1) ur_cnt++;
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 4 * 128 * DIV; n++) begin
            tick();
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL frame_start_timeout: no frame_start within %0d cycles", 4 * 128 * DIV);
        end
    endtask

    task automatic wait_bclk(input logic lvl, output bit ok);
        ok = 1'b1;
        for (int n = 0; ac_bclk !== lvl; n++) begin
            if (n > 4 * DIV + 4) begin
                ok = 1'b0;
                checks++;
                failures++;
                $display("FAIL bclk_timeout: ac_bclk=%b never reached %b", ac_bclk, lvl);
                break;
            end
            tick();
        end
    endtask

    task automatic capture_bits(output logic [63:0] d, output logic [63:0] lr);
        bit ok0, ok1;
        d = '0;
        lr = '0;
        for (int i = 0; i < 64; i++) begin
            wait_bclk(1'b0, ok0);
            wait_bclk(1'b1, ok1);
            if (!(ok0 && ok1)) break;
            d[i]  = ac_pbdat;
            lr[i] = ac_pblrc;
        end
    endtask

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        if (s_ready === 1'b1) sb_q.push_back(p);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        en = 1'b0;
        s_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_valid = 1'b1;
        s_left = 24'h123456;
        s_right = 24'h654321;
        repeat (5) tick();
        checks++;
        if ({ac_bclk, ac_pblrc, ac_pbdat, frame_start, underrun} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 00000", {ac_bclk, ac_pblrc, ac_pbdat, frame_start, underrun});
        end
        checks++;
        if (underrun_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_underrun_cnt: got %h want 0000", underrun_cnt);
        end
        checks++;
        if (fifo_level !== LW'(0)) begin
            failures++;
            $display("FAIL reset_level: got %0d want 0", fifo_level);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready: got %b want 1", s_ready);
        end
        s_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        bit ok;
        int fs0;
        logic [63:0] d, lr, e;
        logic [DW-1:0] lf, rf;
        pair_t p;
        pulse_reset();
        en = 1'b1;
        push_pair(24'hA50FC3, 24'h5AF03C);
        wait_fs(ok);
        fs0 = fs_cnt;
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL basic_underrun: got %b want 0", underrun);
        end
        capture_bits(d, lr);
        checks++;
        if (fs_cnt != fs0) begin
            failures++;
            $display("FAIL basic_fs_once: extra pulses %0d want 0", fs_cnt - fs0);
        end
        checks++;
        if (lr !== {32'hFFFF_FFFF, 32'h0}) begin
            failures++;
            $display("FAIL basic_lrc: got %h want ffffffff00000000", lr);
        end
        lf = '0;
        rf = '0;
        for (int i = 1; i <= DW; i++) begin
            lf = {lf[DW-2:0], d[i]};
            rf = {rf[DW-2:0], d[32+i]};
        end
        checks++;
        if (lf !== 24'hA50FC3 || rf !== 24'h5AF03C) begin
            failures++;
            $display("FAIL basic_samples: got L=%h R=%h want A50FC3 5AF03C", lf, rf);
        end
        checks++;
        if ({d[0], d[31:25], d[32], d[63:57]} !== 16'h0) begin
            failures++;
            $display("FAIL basic_pad_bits: got %h want 0000", {d[0], d[31:25], d[32], d[63:57]});
        end
        p = sb_q.pop_front();
        e = exp_stream(p.l, p.r);
        checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL basic_stream: got %h want %h", d, e);
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_full_backpressure();
        bit ok;
        int acc;
        logic [63:0] d, lr, e;
        pair_t p;
        pulse_reset();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            p.l = DW'($urandom());
            p.r = DW'($urandom());
            s_left = p.l;
            s_right = p.r;
            s_valid = 1'b1;
            if (s_ready === 1'b1) begin
                acc++;
                sb_q.push_back(p);
            end
            tick();
        end
        s_valid = 1'b0;
        checks++;
        if (acc != 4) begin
            failures++;
            $display("FAIL full_accepted: got %0d want 4", acc);
        end
        checks++;
        if (s_ready !== 1'b0 || fifo_level !== LW'(4)) begin
            failures++;
            $display("FAIL full_state: got ready=%b level=%0d want 0 4", s_ready, fifo_level);
        end
        en = 1'b1;
        wait_fs(ok);
        checks++;
        if (fifo_level !== LW'(3)) begin
            failures++;
            $display("FAIL full_first_pop: got level %0d want 3", fifo_level);
        end
        capture_bits(d, lr);
        p = sb_q.pop_front();
        e = exp_stream(p.l, p.r);
        checks++;
        if (d !== e) begin
            failures++;
            $display("FAIL full_frame1: got %h want %h", d, e);
        end
        repeat (DIV - 1) tick();
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_ready_at_3: got %b want 1", s_ready);
        end
        push_pair(24'hC0FFEE, 24'h0BEEF1);
        checks++;
        if (frame_start !== 1'b1 || fifo_level !== LW'(3)) begin
            failures++;
            $display("FAIL full_push_pop_same: got fs=%b level=%0d want 1 3", frame_start, fifo_level);
        end
        for (int f = 0; f < 4; f++) begin
            if (f > 0) wait_fs(ok);
            capture_bits(d, lr);
            p = sb_q.pop_front();
            e = exp_stream(p.l, p.r);
            checks++;
            if (d !== e) begin
                failures++;
                $display("FAIL full_drain_frame%0d: got %h want %h", f, d, e);
            end
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_underrun();
        bit ok;
        int ur0;
        logic [63:0] d, lr, e;
        pair_t p;
        pulse_reset();
        ur0 = ur_cnt;
        en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_fs(ok);
            checks++;
            if (underrun !== 1'b1) begin
                failures++;
                $display("FAIL underrun_pulse%0d: got %b want 1", f, underrun);
            end
            if (f == 2) push_pair(24'h3C3C3C, 24'h811118);
            capture_bits(d, lr);
            checks++;
            if (d !== 64'h0) begin
                failures++;
                $display("FAIL underrun_silent%0d: got %h want 0", f, d);
            end
        end
        checks++;
        if (underrun_cnt !== 16'd3 || ur_cnt - ur0 != 3) begin
            failures++;
            $display("FAIL underrun_count: got cnt=%0d pulses=%0d want 3 3", underrun_cnt, ur_cnt - ur0);
        end
        wait_fs(ok);
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL underrun_recover: got %b want 0", underrun);
        end
        capture_bits(d, lr);
        p = sb_q.pop_front();
        e = exp_stream(p.l, p.r);
        checks++;
        if (d !== e || underrun_cnt !== 16'd3) begin
            failures++;
            $display("FAIL underrun_next_frame: got %h cnt=%0d want %h 3", d, underrun_cnt, e);
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        bit ok;
        int ur0;
        pulse_reset();
        force dut.underrun_cnt_q = 16'hFFFE;
        repeat (2) tick();
        release dut.underrun_cnt_q;
        tick();
        checks++;
        if (underrun_cnt !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_preload: got %h want fffe", underrun_cnt);
        end
        ur0 = ur_cnt;
        en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_fs(ok);
            checks++;
            if (underrun_cnt !== 16'hFFFF) begin
                failures++;
                $display("FAIL sat_hold%0d: got %h want ffff", f, underrun_cnt);
            end
        end
        checks++;
        if (ur_cnt - ur0 != 3) begin
            failures++;
            $display("FAIL sat_pulses: got %0d want 3", ur_cnt - ur0);
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_midop_reset_en();
        bit ok;
        pulse_reset();
        for (int i = 0; i < 3; i++) push_pair(DW'($urandom()), DW'($urandom()));
        en = 1'b1;
        wait_fs(ok);
        checks++;
        if (fifo_level !== LW'(2)) begin
            failures++;
            $display("FAIL midop_queued: got level %0d want 2", fifo_level);
        end
        for (int i = 0; i < 40; i++) begin
            wait_bclk(1'b1, ok);
            wait_bclk(1'b0, ok);
        end
        checks++;
        if (ac_pblrc !== 1'b1) begin
            failures++;
            $display("FAIL midop_bit40_lrc: got %b want 1", ac_pblrc);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({ac_bclk, ac_pblrc, ac_pbdat, frame_start, underrun, s_ready} !== 6'b000001 || fifo_level !== LW'(0)) begin
            failures++;
            $display("FAIL midop_reset: got %b level=%0d want 000001 0",
                     {ac_bclk, ac_pblrc, ac_pbdat, frame_start, underrun, s_ready}, fifo_level);
        end
        reset = 1'b0;
        sb_q.delete();
        push_pair(24'hFFFFFF, 24'h000000);
        wait_fs(ok);
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL midop_reload: got underrun %b want 0", underrun);
        end
        for (int i = 0; i < 10; i++) begin
            wait_bclk(1'b1, ok);
            wait_bclk(1'b0, ok);
        end
        wait_bclk(1'b1, ok);
        checks++;
        if ({ac_bclk, ac_pblrc, ac_pbdat} !== 3'b101) begin
            failures++;
            $display("FAIL midop_bit10: got %b want 101", {ac_bclk, ac_pblrc, ac_pbdat});
        end
        en = 1'b0;
        tick();
        checks++;
        if ({ac_bclk, ac_pblrc, ac_pbdat} !== 3'b000 || fifo_level !== LW'(0)) begin
            failures++;
            $display("FAIL midop_en_drop: got %b level=%0d want 000 0", {ac_bclk, ac_pblrc, ac_pbdat}, fifo_level);
        end
        sb_q.delete();
        en = 1'b1;
        wait_fs(ok);
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL midop_pair_lost: got underrun %b want 1", underrun);
        end
        en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_full_backpressure();
        test_underrun();
        test_saturation();
        test_midop_reset_en();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
